// File: rtl/alu_mc.sv
// Multi-cycle RV-style integer ALU: single-cycle base ops, iterative shift-add MUL
// and restoring DIV/REM (one bit per cycle), with a valid/ready request/result handshake.
module alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [2:0]      funct3_alu,
    input  logic            Type_alu,
    input  logic            m_ext,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   result_reg, result_next;
    logic [SHW-1:0]    cnt_reg, cnt_next;
    logic [XLEN-1:0]   acc_reg, acc_next;
    logic [XLEN-1:0]   opa_reg, opa_next;
    logic [XLEN-1:0]   opb_reg, opb_next;
    logic              is_mul_reg, is_mul_next;
    logic              rem_sel_reg, rem_sel_next;
    logic              neg_reg, neg_next;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs at acceptance
    // ------------------------------------------------------------------
    logic [SHW-1:0]    shamt;
    logic              shift_left;
    logic              shift_fill;
    logic [XLEN-1:0]   op1_rev;
    logic [XLEN-1:0]   shr_out;
    logic [XLEN-1:0]   shl_res;
    logic [XLEN-1:0]   shr_stage [0:SHW];
    logic [XLEN-1:0]   add_res;
    logic              slt_res;
    logic              sltu_res;
    logic [XLEN-1:0]   base_res;

    assign shamt      = operand2[SHW-1:0];
    assign shift_left = (funct3_alu == 3'b001);
    assign shift_fill = (funct3_alu == 3'b101) && Type_alu && operand1[XLEN-1];

    // Left shifts reuse the right-shift network on a bit-reversed operand
    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_rev
            assign op1_rev[gi] = operand1[XLEN-1-gi];
            assign shl_res[gi] = shr_out[XLEN-1-gi];
        end
    endgenerate

    assign shr_stage[0] = shift_left ? op1_rev : operand1;

    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_shift
            localparam int STEP = 1 << gi;
            assign shr_stage[gi+1] = shamt[gi]
                ? {{STEP{shift_fill}}, shr_stage[gi][XLEN-1:STEP]}
                : shr_stage[gi];
        end
    endgenerate

    assign shr_out  = shr_stage[SHW];
    assign add_res  = (Type_alu && funct3_alu == 3'b000) ? (operand1 - operand2)
                                                        : (operand1 + operand2);
    assign slt_res  = $signed(operand1) < $signed(operand2);
    assign sltu_res = operand1 < operand2;

    always_comb begin
        base_res = '0;
        case (funct3_alu)
            3'b000:  base_res = add_res;
            3'b001:  base_res = shl_res;
            3'b010:  base_res = {{(XLEN-1){1'b0}}, slt_res};
            3'b011:  base_res = {{(XLEN-1){1'b0}}, sltu_res};
            3'b100:  base_res = operand1 ^ operand2;
            3'b101:  base_res = shr_out;
            3'b110:  base_res = operand1 | operand2;
            default: base_res = operand1 & operand2;
        endcase
    end

    // ------------------------------------------------------------------
    // M-extension setup: magnitudes, sign fix-up flags and fast paths
    // ------------------------------------------------------------------
    logic              div_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic              mul_op;
    logic              start_iter;
    logic [XLEN-1:0]   quick_res;

    assign div_signed = ~funct3_alu[0];
    assign a_neg      = div_signed & operand1[XLEN-1];
    assign b_neg      = div_signed & operand2[XLEN-1];
    assign a_mag      = a_neg ? (~operand1 + 1'b1) : operand1;
    assign b_mag      = b_neg ? (~operand2 + 1'b1) : operand2;
    assign div_zero   = (operand2 == '0);
    assign div_ovf    = div_signed && (operand1 == MOST_NEG) && (operand2 == ALL_ONES);
    assign mul_op     = (funct3_alu == 3'b000);
    assign start_iter = m_ext && (mul_op || (funct3_alu[2] && !div_zero && !div_ovf));

    // funct3[1] selects remainder among the divide group
    always_comb begin
        quick_res = '0;
        if (!m_ext) begin
            quick_res = base_res;
        end else if (funct3_alu[2]) begin
            if (div_zero) begin
                quick_res = funct3_alu[1] ? operand1 : ALL_ONES;
            end else if (div_ovf) begin
                quick_res = funct3_alu[1] ? '0 : operand1;
            end
        end
    end

    // ------------------------------------------------------------------
    // One iteration step of shift-add multiply / restoring divide
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   mul_acc;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_final;

    assign mul_acc   = acc_reg + (opa_reg[0] ? opb_reg : '0);
    assign rem_sh    = {acc_reg, opa_reg[XLEN-1]};
    assign div_diff  = rem_sh - {1'b0, opb_reg};
    assign div_ge    = ~div_diff[XLEN];
    assign div_rem   = div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign div_quo   = {opa_reg[XLEN-2:0], div_ge};
    assign div_final = rem_sel_reg ? (neg_reg ? (~div_rem + 1'b1) : div_rem)
                                   : (neg_reg ? (~div_quo + 1'b1) : div_quo);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        opa_next     = opa_reg;
        opb_next     = opb_reg;
        is_mul_next  = is_mul_reg;
        rem_sel_next = rem_sel_reg;
        neg_next     = neg_reg;
        case (state_reg)
            IDLE: begin
                if (op_valid) begin
                    if (start_iter) begin
                        state_next   = CALC;
                        cnt_next     = '0;
                        acc_next     = '0;
                        is_mul_next  = mul_op;
                        rem_sel_next = funct3_alu[1];
                        neg_next     = funct3_alu[1] ? a_neg : (a_neg ^ b_neg);
                        opa_next     = mul_op ? operand2 : a_mag;
                        opb_next     = mul_op ? operand1 : b_mag;
                    end else begin
                        state_next  = DONE;
                        result_next = quick_res;
                    end
                end
            end
            CALC: begin
                cnt_next = cnt_reg + 1'b1;
                if (is_mul_reg) begin
                    acc_next = mul_acc;
                    opa_next = opa_reg >> 1;
                    opb_next = opb_reg << 1;
                end else begin
                    acc_next = div_rem;
                    opa_next = div_quo;
                end
                if (cnt_reg == CNT_LAST) begin
                    state_next  = DONE;
                    result_next = is_mul_reg ? mul_acc : div_final;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            opa_reg     <= '0;
            opb_reg     <= '0;
            is_mul_reg  <= 1'b0;
            rem_sel_reg <= 1'b0;
            neg_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            opa_reg     <= opa_next;
            opb_reg     <= opb_next;
            is_mul_reg  <= is_mul_next;
            rem_sel_reg <= rem_sel_next;
            neg_reg     <= neg_next;
        end
    end

    assign op_ready  = (state_reg == IDLE);
    assign res_valid = (state_reg == DONE);
    assign busy      = (state_reg == CALC);
    assign result    = result_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc (XLEN=32): results, latency, busy
// duration, result hold under back-pressure and reset abort during CALC.
module tb_alu_mc;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            op_valid;
    logic            op_ready;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [2:0]      funct3_alu;
    logic            Type_alu;
    logic            m_ext;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int checks;
    int errors;

    alu_mc #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .operand1   (operand1),
        .operand2   (operand2),
        .funct3_alu (funct3_alu),
        .Type_alu   (Type_alu),
        .m_ext      (m_ext),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .result     (result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        m;
        logic [2:0]  f3;
        logic        t;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, measure latency and busy cycles.
    task automatic do_op(input logic m, input logic [2:0] f3, input logic t,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cnt);
        int guard;
        guard = 0;
        while (!op_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        m_ext = m; funct3_alu = f3; Type_alu = t; operand1 = a; operand2 = b;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        operand1 = $urandom; operand2 = $urandom;
        funct3_alu = 3'($urandom); Type_alu = ~t; m_ext = ~m;
        lat = 1;
        busy_cnt = 0;
        while (!res_valid && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        int lat;
        int bcnt;
        int seen;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        op_valid = 1'b0;
        res_ready = 1'b0;
        operand1 = '0;
        operand2 = '0;
        funct3_alu = '0;
        Type_alu = 1'b0;
        m_ext = 1'b0;

        //            name        m   f3      t   a             b             expected      lat
        vecs.push_back('{"add_wrap", 1'b0, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
        vecs.push_back('{"sub",      1'b0, 3'b000, 1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1});
        vecs.push_back('{"sll",      1'b0, 3'b001, 1'b0, 32'h00000001, 32'h00000023, 32'h00000008, 1});
        vecs.push_back('{"slt",      1'b0, 3'b010, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1});
        vecs.push_back('{"sltu",     1'b0, 3'b011, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1});
        vecs.push_back('{"xor",      1'b0, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1});
        vecs.push_back('{"srl",      1'b0, 3'b101, 1'b0, 32'h80000000, 32'h00000024, 32'h08000000, 1});
        vecs.push_back('{"sra",      1'b0, 3'b101, 1'b1, 32'h80000000, 32'h00000024, 32'hF8000000, 1});
        vecs.push_back('{"or_t1",    1'b0, 3'b110, 1'b1, 32'h000000F0, 32'h00000F00, 32'h00000FF0, 1});
        vecs.push_back('{"and",      1'b0, 3'b111, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1});
        vecs.push_back('{"mul_hi",   1'b1, 3'b000, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 33});
        vecs.push_back('{"mul_neg",  1'b1, 3'b000, 1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 33});
        vecs.push_back('{"div_m7_2", 1'b1, 3'b100, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
        vecs.push_back('{"rem_m7_2", 1'b1, 3'b110, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
        vecs.push_back('{"div_7_m2", 1'b1, 3'b100, 1'b0, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
        vecs.push_back('{"rem_7_m2", 1'b1, 3'b110, 1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
        vecs.push_back('{"divu",     1'b1, 3'b101, 1'b0, 32'h00000064, 32'h00000007, 32'h0000000E, 33});
        vecs.push_back('{"remu",     1'b1, 3'b111, 1'b0, 32'h00000064, 32'h00000007, 32'h00000002, 33});
        vecs.push_back('{"divu_big", 1'b1, 3'b101, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
        vecs.push_back('{"divu_z",   1'b1, 3'b101, 1'b0, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
        vecs.push_back('{"remu_z",   1'b1, 3'b111, 1'b0, 32'h00000005, 32'h00000000, 32'h00000005, 1});
        vecs.push_back('{"div_z",    1'b1, 3'b100, 1'b0, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
        vecs.push_back('{"div_ovf",  1'b1, 3'b100, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{"rem_ovf",  1'b1, 3'b110, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
        vecs.push_back('{"m_rsvd",   1'b1, 3'b010, 1'b0, 32'h00000003, 32'h00000004, 32'h00000000, 1});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 32'h0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_op_ready", {31'b0, op_ready}, 32'h1);

        // Table-driven vectors; the first is accepted on the first edge after release
        foreach (vecs[i]) begin
            do_op(vecs[i].m, vecs[i].f3, vecs[i].t, vecs[i].a, vecs[i].b, res, lat, bcnt);
            chk(vecs[i].name, res, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            chk({vecs[i].name, "_busy"}, 32'(bcnt), 32'(vecs[i].lat - 1));
            $display("op %0s a=%h b=%h result=%h lat=%0d busy=%0d",
                     vecs[i].name, vecs[i].a, vecs[i].b, res, lat, bcnt);
        end

        // Back-pressure: result held for 10 cycles, new requests ignored in DONE
        m_ext = 1'b0; funct3_alu = 3'b000; Type_alu = 1'b0;
        operand1 = 32'd3; operand2 = 32'd4; op_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            operand1 = $urandom; operand2 = $urandom;
            chk("hold_result", result, 32'h7);
            chk("hold_res_valid", {31'b0, res_valid}, 32'h1);
            chk("hold_op_ready", {31'b0, op_ready}, 32'h0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("hold_release_idle", {31'b0, op_ready}, 32'h1);
        chk("hold_release_valid", {31'b0, res_valid}, 32'h0);
        op_valid = 1'b0;
        $display("op hold result=7 released to idle op_ready=%0b", op_ready);

        // Reset during CALC aborts the operation
        m_ext = 1'b1; funct3_alu = 3'b101; operand1 = 32'd100; operand2 = 32'd3;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("abort_busy_before", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_result", result, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_res_valid", {31'b0, res_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'h0);
        chk("abort_op_ready", {31'b0, op_ready}, 32'h1);
        chk("abort_result_after", result, 32'h0);
        $display("op abort res_valid_seen=%0d result=%h", seen, result);

        // Normal operation after abort
        do_op(1'b1, 3'b101, 1'b0, 32'd100, 32'd3, res, lat, bcnt);
        chk("post_abort_divu", res, 32'd33);
        chk("post_abort_lat", 32'(lat), 32'd33);
        $display("op post_abort divu result=%h lat=%0d", res, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
